// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic {S_INIT, S_RUN} sram_ctrl_state_e;

  function automatic int unsigned lanes(input int unsigned data_width,
                                        input int unsigned byte_size);
    return data_width / byte_size;
  endfunction

endpackage

// File: rtl/sram_resp_buf.sv
// Circular response FIFO; the head entry is presented combinationally.
module sram_resp_buf
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 3,
  localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;

  // Explicit wrap compare so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= w_wr_ptr_nxt;
      end
      if (i_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Valid/ready initiator for one SRAM port with credit-limited in-order responses
// and optional zero-fill of the array after reset.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_DEPTH    = 1024,
  parameter int unsigned BYTE_SIZE     = 32,
  parameter int unsigned RESP_DEPTH    = 3,
  parameter int unsigned INIT_ON_RESET = 1,
  localparam int unsigned LANES        = lanes(DATA_WIDTH, BYTE_SIZE),
  localparam int unsigned AW           = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [LANES-1:0]      req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  init_done_o,
  output logic                  sram_en_o,
  output logic [LANES-1:0]      sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  if (DATA_WIDTH % BYTE_SIZE != 0) begin : g_bad_lane_width
    $error("DATA_WIDTH must be a multiple of BYTE_SIZE");
  end
  if (RESP_DEPTH < 2) begin : g_bad_resp_depth
    $error("RESP_DEPTH must be at least 2");
  end

  sram_ctrl_state_e r_state;
  logic [AW-1:0]    r_init_cnt;
  logic             r_init_done;
  logic             r_inflight;

  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic             w_credit;
  logic             w_fire;
  logic             w_pop;

  // Credits count both buffered and in-flight responses so a push can never overflow.
  assign w_credit    = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < (CW + 1)'(RESP_DEPTH);
  assign req_ready_o = (r_state == S_RUN) && w_credit;
  assign w_fire      = req_valid_i && req_ready_o;
  assign w_pop       = resp_valid_o && resp_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      r_init_cnt  <= '0;
      r_init_done <= (INIT_ON_RESET == 0);
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_fire;
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == AW'(DATA_DEPTH - 1)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + AW'(1);
          end
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Gating with rst_n keeps the port quiet while reset is held, even though the state reads INIT.
  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = '0;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    if (r_state == S_INIT) begin
      sram_en_o    = rst_n;
      sram_we_o    = {LANES{rst_n}};
      sram_addr_o  = r_init_cnt;
      sram_wdata_o = '0;
    end else if (w_fire) begin
      sram_en_o = 1'b1;
      sram_we_o = req_we_i;
    end
  end

  sram_resp_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RESP_DEPTH)
  ) u_resp_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_wdata(sram_rdata_i),
    .i_pop  (w_pop),
    .o_rdata(resp_rdata_o),
    .o_count(w_count),
    .o_empty(w_empty)
  );

  assign resp_valid_o = !w_empty;
  assign init_done_o  = r_init_done;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural write-first SRAM attached.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_addr_i = '0;
  logic [3:0]  req_we_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        init_done_o;
  logic        sram_en_o;
  logic [3:0]  sram_we_o;
  logic [3:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i = '0;

  int   checks = 0;
  int   errors = 0;
  logic ovf_seen = 1'b0;

  always #5 clk = ~clk;

  sram_access_ctrl #(
    .DATA_WIDTH   (32),
    .DATA_DEPTH   (16),
    .BYTE_SIZE    (8),
    .RESP_DEPTH   (3),
    .INIT_ON_RESET(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .init_done_o (init_done_o),
    .sram_en_o   (sram_en_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i)
  );

  logic [31:0] mem [16];

  always @(posedge clk) begin : sram_model
    logic [31:0] merged;
    if (sram_en_o) begin
      merged = mem[sram_addr_o];
      for (int l = 0; l < 4; l++)
        if (sram_we_o[l]) merged[l*8 +: 8] = sram_wdata_o[l*8 +: 8];
      mem[sram_addr_o] = merged;
      sram_rdata_i <= merged;
    end
  end

  always @(posedge clk) begin
    if (rst_n && dut.u_resp_buf.i_push && !dut.u_resp_buf.i_pop &&
        dut.u_resp_buf.o_count == 2'd3) ovf_seen <= 1'b1;
    if (rst_n && dut.u_resp_buf.i_pop && dut.u_resp_buf.o_empty) ovf_seen <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hBAD0_0000 + 32'(i);
    step();
    step();
    checks++;
    if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'h0 ||
        init_done_o !== 1'b0 || sram_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b rvalid=%b rdata=%h done=%b en=%b, want all 0",
               req_ready_o, resp_valid_o, resp_rdata_o, init_done_o, sram_en_o);
    end
    step();
  endtask

  // Releases reset and walks the zero-fill sequence.
  task automatic test_init();
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sram_en_o !== 1'b1 || sram_we_o !== 4'hF || sram_addr_o !== 4'(i) ||
          sram_wdata_o !== 32'h0) begin
        errors++;
        $display("FAIL init_write%0d: en=%b we=%h addr=%0d wdata=%h, want en=1 we=f addr=%0d wdata=0",
                 i, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o, i);
      end
      checks++;
      if (req_ready_o !== 1'b0 || init_done_o !== 1'b0) begin
        errors++;
        $display("FAIL init_busy%0d: ready=%b done=%b, want 0 0", i, req_ready_o, init_done_o);
      end
      step();
    end
    checks++;
    if (init_done_o !== 1'b1 || req_ready_o !== 1'b1 || sram_en_o !== 1'b0 ||
        resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL init_end: done=%b ready=%b en=%b rvalid=%b, want 1 1 0 0",
               init_done_o, req_ready_o, sram_en_o, resp_valid_o);
    end
  endtask

  task automatic test_write_read();
    logic [3:0] we_t [2] = '{4'hF, 4'h0};
    resp_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) begin
        req_valid_i = 1'b1; req_addr_i = 4'd5; req_we_i = we_t[c]; req_wdata_i = 32'hDEADBEEF;
        checks++;
        if (req_ready_o !== 1'b1) begin
          errors++; $display("FAIL wr_rd_fire%0d: ready=%b, want 1", c, req_ready_o);
        end
      end else begin
        req_valid_i = 1'b0; req_we_i = '0;
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (resp_valid_o !== 1'b0) begin
          errors++; $display("FAIL wr_rd_idle%0d: rvalid=%b, want 0", c, resp_valid_o);
        end
      end else if (c >= 2) begin
        checks++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL wr_rd_resp%0d: rvalid=%b rdata=%h, want 1 deadbeef", c - 2, resp_valid_o, resp_rdata_o);
        end
      end
      step();
    end
  endtask

  task automatic test_lanes();
    logic [3:0]  we_t [3] = '{4'hF, 4'b0010, 4'h0};
    logic [31:0] wd_t [3] = '{32'h11223344, 32'hAAAAAAAA, 32'h0};
    logic [31:0] ex_t [3] = '{32'h11223344, 32'h1122AA44, 32'h1122AA44};
    resp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        req_valid_i = 1'b1; req_addr_i = 4'd3; req_we_i = we_t[c]; req_wdata_i = wd_t[c];
        checks++;
        if (req_ready_o !== 1'b1) begin
          errors++; $display("FAIL lanes_fire%0d: ready=%b, want 1", c, req_ready_o);
        end
      end else begin
        req_valid_i = 1'b0; req_we_i = '0;
      end
      if (c >= 2 && c < 5) begin
        checks++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== ex_t[c-2]) begin
          errors++;
          $display("FAIL lanes_resp%0d: rvalid=%b rdata=%h, want 1 %h", c - 2, resp_valid_o, resp_rdata_o, ex_t[c-2]);
        end
      end else if (c == 5) begin
        checks++;
        if (resp_valid_o !== 1'b0) begin
          errors++; $display("FAIL lanes_idle: rvalid=%b, want 0", resp_valid_o);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ex_t [8] = '{32'h0, 32'h0, 32'h0, 32'h1122AA44, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    resp_ready_i = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        req_valid_i = 1'b1; req_addr_i = 4'(c); req_we_i = '0;
        checks++;
        if (req_ready_o !== 1'b1) begin
          errors++; $display("FAIL b2b_fire%0d: ready=%b, want 1", c, req_ready_o);
        end
      end else begin
        req_valid_i = 1'b0;
      end
      if (c >= 2 && c < 10) begin
        checks++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== ex_t[c-2]) begin
          errors++;
          $display("FAIL b2b_resp%0d: rvalid=%b rdata=%h, want 1 %h", c - 2, resp_valid_o, resp_rdata_o, ex_t[c-2]);
        end
      end else if (c == 10) begin
        checks++;
        if (resp_valid_o !== 1'b0) begin
          errors++; $display("FAIL b2b_idle: rvalid=%b, want 0", resp_valid_o);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    resp_ready_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        req_valid_i = 1'b1; req_addr_i = 4'(8 + c); req_we_i = 4'hF; req_wdata_i = 32'hC0DE_0000 + 32'(c);
      end else begin
        req_valid_i = 1'b0; req_we_i = '0;
      end
      if (c >= 2 && c < 8) begin
        checks++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hC0DE_0000 + 32'(c - 2)) begin
          errors++;
          $display("FAIL bp_fill%0d: rvalid=%b rdata=%h, want 1 %h", c - 2, resp_valid_o, resp_rdata_o, 32'hC0DE_0000 + 32'(c - 2));
        end
      end
      step();
    end
    resp_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      req_valid_i = (idx < 6); req_addr_i = 4'(8 + idx); req_we_i = '0;
      if (req_valid_i && req_ready_o) idx++;
      step();
    end
    checks++;
    if (idx != 3 || req_ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_stall: fires=%0d ready=%b, want 3 0", idx, req_ready_o);
    end
    checks++;
    if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hC0DE_0000) begin
      errors++; $display("FAIL bp_head_hold: rvalid=%b rdata=%h, want 1 c0de0000", resp_valid_o, resp_rdata_o);
    end
    resp_ready_i = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      req_valid_i = (idx < 6); req_addr_i = 4'(8 + idx); req_we_i = '0;
      if (req_valid_i && req_ready_o) idx++;
      if (resp_valid_o) begin
        checks++;
        if (resp_rdata_o !== 32'hC0DE_0000 + 32'(got)) begin
          errors++;
          $display("FAIL bp_drain%0d: rdata=%h, want %h", got, resp_rdata_o, 32'hC0DE_0000 + 32'(got));
        end
        got++;
      end
      step();
    end
    req_valid_i = 1'b0;
    checks++;
    if (got != 6 || idx != 6) begin
      errors++; $display("FAIL bp_total: responses=%0d fires=%0d, want 6 6", got, idx);
    end
  endtask

  task automatic test_reset_midstream();
    resp_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid_i = (c < 2); req_addr_i = (c == 0) ? 4'd5 : 4'd3; req_we_i = '0;
      step();
    end
    req_valid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_pending: rvalid=%b, want 1", resp_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || sram_en_o !== 1'b0 || req_ready_o !== 1'b0 ||
        init_done_o !== 1'b0 || resp_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: rvalid=%b en=%b ready=%b done=%b rdata=%h, want 0 0 0 0 0",
               resp_valid_o, sram_en_o, req_ready_o, init_done_o, resp_rdata_o);
    end
    step();
    step();
    test_init();
    resp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 4'd5; req_we_i = '0;
    step();
    req_valid_i = 1'b0;
    step();
    checks++;
    if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL mid_reread: rvalid=%b rdata=%h, want 1 0", resp_valid_o, resp_rdata_o);
    end
    step();
    checks++;
    if (resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_dropped: rvalid=%b, want 0", resp_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_lanes();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    checks++;
    if (ovf_seen !== 1'b0) begin
      errors++; $display("FAIL buf_guard: overflow_or_empty_pop=%b, want 0", ovf_seen);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
